// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and captured-command payload for the ALU command engine.
package alu_pkg;

    localparam int unsigned ALU_SIZE  = 4;
    localparam int unsigned ALU_NREGS = 4;
    localparam int unsigned ALU_RW    = $clog2(ALU_NREGS);
    localparam int unsigned OP_W      = 3;

    localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
    localparam logic [OP_W-1:0] OP_AND  = 3'b010;
    localparam logic [OP_W-1:0] OP_OR   = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
    localparam logic [OP_W-1:0] OP_SHL  = 3'b101;
    localparam logic [OP_W-1:0] OP_SHR  = 3'b110;
    localparam logic [OP_W-1:0] OP_PASS = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Field widths follow the package defaults that the engine parameters default to.
    typedef struct packed {
        logic [OP_W-1:0]     op;
        logic [ALU_RW-1:0]   rd;
        logic [ALU_RW-1:0]   rs1;
        logic [ALU_RW-1:0]   rs2;
        logic                imm_sel;
        logic [ALU_SIZE-1:0] imm;
    } cmd_t;

endpackage

// File: rtl/alu_cmd_engine_if.sv
// Command and response valid/ready channels between an issuer and the ALU command engine.
interface alu_cmd_engine_if #(
    parameter int unsigned SIZE  = 4,
    parameter int unsigned NREGS = 4
);
    localparam int unsigned RW = $clog2(NREGS);

    logic            cmd_valid;
    logic            cmd_ready;
    logic [2:0]      cmd_op;
    logic [RW-1:0]   cmd_rd;
    logic [RW-1:0]   cmd_rs1;
    logic [RW-1:0]   cmd_rs2;
    logic            cmd_imm_sel;
    logic [SIZE-1:0] cmd_imm;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [SIZE-1:0] rsp_data;
    logic            rsp_carry;
    logic [RW-1:0]   rsp_rd;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_sel, cmd_imm, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_rd
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_sel, cmd_imm, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_rd
    );

endinterface

// File: rtl/alu_datapath.sv
// Combinational ALU: arithmetic, logic and logical shifts on SIZE-bit operands with carry/borrow.
module alu_datapath
    import alu_pkg::*;
#(
    parameter int unsigned SIZE = ALU_SIZE
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic [2:0]      op,
    output logic [SIZE-1:0] result_c,
    output logic            carry_c
);

    localparam logic [SIZE-1:0] SHAMT_LIMIT = SIZE'(SIZE);

    logic [SIZE:0] sum;
    logic [SIZE:0] diff;
    logic          shift_oob;

    always_comb begin
        sum       = {1'b0, a} + {1'b0, b};
        diff      = {1'b0, a} - {1'b0, b};
        shift_oob = (b >= SHAMT_LIMIT);
        result_c  = '0;
        carry_c   = 1'b0;
        // Unknown or X opcodes fall through to the zero default.
        case (op)
            OP_ADD: begin
                result_c = sum[SIZE-1:0];
                carry_c  = sum[SIZE];
            end
            OP_SUB: begin
                result_c = diff[SIZE-1:0];
                carry_c  = diff[SIZE];
            end
            OP_AND:  result_c = a & b;
            OP_OR:   result_c = a | b;
            OP_XOR:  result_c = a ^ b;
            OP_SHL:  result_c = shift_oob ? '0 : (a << b);
            OP_SHR:  result_c = shift_oob ? '0 : (a >> b);
            OP_PASS: result_c = a;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_cmd_engine.sv
// Sequential ALU command front-end: accepts a command, reads the register file, executes,
// writes back and returns the result over a held response channel.
module alu_cmd_engine
    import alu_pkg::*;
#(
    parameter int unsigned SIZE  = ALU_SIZE,
    parameter int unsigned NREGS = ALU_NREGS,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_cmd_engine_if.slave  bus,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    localparam int unsigned RW = $clog2(NREGS);

    state_t          state;
    state_t          next_state;
    cmd_t            cmd_q;
    logic [SIZE-1:0] regs [NREGS];

    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             busy_q, busy_d;
    logic [SIZE-1:0]  rsp_data_q;
    logic             rsp_carry_q;
    logic [RW-1:0]    rsp_rd_q;
    logic [CNT_W-1:0] ops_done_q;

    logic            cmd_fire;
    logic            rsp_fire;
    logic [RW-1:0]   rs1_idx;
    logic [RW-1:0]   rs2_idx;
    logic [RW-1:0]   rd_idx;
    logic [SIZE-1:0] op_a;
    logic [SIZE-1:0] op_b;
    logic [SIZE-1:0] alu_result;
    logic            alu_carry;

    assign cmd_fire = bus.cmd_valid && cmd_ready_q;
    assign rsp_fire = rsp_valid_q && bus.rsp_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cmd_fire) next_state = EXEC;
            EXEC:    next_state = RESP;
            RESP:    if (rsp_fire) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered flags line up with it.
    always_comb begin
        cmd_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        busy_d      = 1'b1;
        case (next_state)
            IDLE: begin
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
            RESP:    rsp_valid_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Operand fetch; register 0 always reads as zero.
    always_comb begin
        rs1_idx = RW'(cmd_q.rs1);
        rs2_idx = RW'(cmd_q.rs2);
        rd_idx  = RW'(cmd_q.rd);
        op_a    = (rs1_idx == '0) ? '0 : regs[rs1_idx];
        op_b    = (rs2_idx == '0) ? '0 : regs[rs2_idx];
        if (cmd_q.imm_sel) begin
            op_b = SIZE'(cmd_q.imm);
        end
    end

    alu_datapath #(
        .SIZE (SIZE)
    ) u_datapath (
        .a        (op_a),
        .b        (op_b),
        .op       (cmd_q.op),
        .result_c (alu_result),
        .carry_c  (alu_carry)
    );

    // Command capture, write-back, response payload and completion counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q       <= '0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_rd_q    <= '0;
            ops_done_q  <= '0;
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (state == IDLE && cmd_fire) begin
                cmd_q.op      <= bus.cmd_op;
                cmd_q.rd      <= ALU_RW'(bus.cmd_rd);
                cmd_q.rs1     <= ALU_RW'(bus.cmd_rs1);
                cmd_q.rs2     <= ALU_RW'(bus.cmd_rs2);
                cmd_q.imm_sel <= bus.cmd_imm_sel;
                cmd_q.imm     <= ALU_SIZE'(bus.cmd_imm);
            end
            if (state == EXEC) begin
                if (rd_idx != '0) begin
                    regs[rd_idx] <= alu_result;
                end
                rsp_data_q  <= alu_result;
                rsp_carry_q <= alu_carry;
                rsp_rd_q    <= rd_idx;
            end
            if (state == RESP && rsp_fire) begin
                ops_done_q <= ops_done_q + CNT_W'(1);
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_carry = rsp_carry_q;
    assign bus.rsp_rd    = rsp_rd_q;
    assign busy          = busy_q;
    assign ops_done      = ops_done_q;

endmodule
